// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer for base^exp mod p around an external
// 128-bit modular multiplier. One multiply is in flight at a time; each
// issue waits for the multiplier's valid, so any latency >= 1 works.
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | waiting for start
// SQR_ISSUE   | present acc*acc to the multiplier
// SQR_WAIT    | waiting for the square result
// MUL_ISSUE   | present acc*base to the multiplier
// MUL_WAIT    | waiting for the multiply result
// DONE        | result valid, one-cycle done pulse
module mod_exp_ctrl #(
  parameter int EXP_W = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [127:0]     base,
  input  logic [EXP_W-1:0] exp,
  output logic             busy,
  output logic             done,
  output logic [127:0]     result,
  output logic             mul_in_valid,
  output logic [127:0]     mul_a,
  output logic [127:0]     mul_b,
  input  logic             mul_out_valid,
  input  logic [127:0]     mul_c
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [127:0]       acc, acc_n;
  logic [127:0]       base_q, base_n;
  logic [EXP_W-1:0]   exp_q, exp_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [127:0]       result_n;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= 128'd0;
      base_q <= 128'd0;
      exp_q  <= '0;
      idx    <= '0;
      result <= 128'd0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      base_q <= base_n;
      exp_q  <= exp_n;
      idx    <= idx_n;
      result <= result_n;
    end
  end

  // Next-state, datapath updates and Moore outputs
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    base_n       = base_q;
    exp_n        = exp_q;
    idx_n        = idx;
    result_n     = result;
    mul_in_valid = 1'b0;
    mul_a        = 128'd0;
    mul_b        = 128'd0;
    done         = 1'b0;
    busy         = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          base_n   = base;
          exp_n    = exp;
          acc_n    = 128'd1;
          idx_n    = IDX_LAST;
          result_n = 128'd0;
          state_n  = S_SQR_ISSUE;
        end
      end
      S_SQR_ISSUE: begin
        mul_in_valid = 1'b1;
        mul_a        = acc;
        mul_b        = acc;
        state_n      = S_SQR_WAIT;
      end
      S_SQR_WAIT: begin
        if (mul_out_valid) begin
          acc_n = mul_c;
          if (exp_q[idx]) begin
            state_n = S_MUL_ISSUE;
          end else if (idx == '0) begin
            result_n = mul_c;
            state_n  = S_DONE;
          end else begin
            idx_n   = idx - IDX_W'(1);
            state_n = S_SQR_ISSUE;
          end
        end
      end
      S_MUL_ISSUE: begin
        mul_in_valid = 1'b1;
        mul_a        = acc;
        mul_b        = base_q;
        state_n      = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mul_out_valid) begin
          acc_n = mul_c;
          if (idx == '0) begin
            result_n = mul_c;
            state_n  = S_DONE;
          end else begin
            idx_n   = idx - IDX_W'(1);
            state_n = S_SQR_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Cancel wins over everything outside IDLE; working values are kept.
    if (abort && (state != S_IDLE)) begin
      state_n  = S_IDLE;
      acc_n    = acc;
      idx_n    = idx;
      result_n = result;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: three instances (EXP_W 8, 128, 4), each with a
// latency-programmable multiplier model, checked against a right-to-left
// exponentiation reference and closed-form latency.
module tb_mod_exp_ctrl;

  localparam logic [127:0] P = (128'd1 << 127) + 128'h1B8001;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         start_v [3];
  logic         abort;
  logic [127:0] base_b, exp_b;
  logic         bz [3], dn [3], mv [3], ov [3];
  logic [127:0] rs [3], ma [3], mb [3], mc [3];
  logic         vp [3][8];
  logic [127:0] dp [3][8];
  int           lat [3];
  int           n_vec = 0, n_err = 0;

  function automatic logic [127:0] mulmod(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] pr;
    pr = {128'd0, a} * {128'd0, b};
    return 128'(pr % {128'd0, P});
  endfunction

  function automatic logic [127:0] powmod(input logic [127:0] b, input logic [127:0] e, input int w);
    logic [127:0] r, s;
    r = 128'd1;
    s = 128'(({128'd0, b}) % {128'd0, P});
    for (int i = 0; i < w; i++) begin
      if (e[i]) r = mulmod(r, s);
      s = mulmod(s, s);
    end
    return r;
  endfunction

  // Multiplier model: fixed pipeline, response tapped at stage lat-1
  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int s = 0; s < 8; s++) begin
          vp[k][s] <= 1'b0;
          dp[k][s] <= 128'd0;
        end
      end else begin
        for (int s = 7; s > 0; s--) begin
          vp[k][s] <= vp[k][s-1];
          dp[k][s] <= dp[k][s-1];
        end
        vp[k][0] <= mv[k];
        dp[k][0] <= mv[k] ? mulmod(ma[k], mb[k]) : 128'd0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ov[k] = vp[k][lat[k]-1];
      mc[k] = dp[k][lat[k]-1];
    end
  end

  mod_exp_ctrl #(.EXP_W(8)) u8 (
    .clock(clock), .reset(reset), .start(start_v[0]), .abort(abort),
    .base(base_b), .exp(exp_b[7:0]), .busy(bz[0]), .done(dn[0]), .result(rs[0]),
    .mul_in_valid(mv[0]), .mul_a(ma[0]), .mul_b(mb[0]),
    .mul_out_valid(ov[0]), .mul_c(mc[0]));

  mod_exp_ctrl #(.EXP_W(128)) u128 (
    .clock(clock), .reset(reset), .start(start_v[1]), .abort(abort),
    .base(base_b), .exp(exp_b), .busy(bz[1]), .done(dn[1]), .result(rs[1]),
    .mul_in_valid(mv[1]), .mul_a(ma[1]), .mul_b(mb[1]),
    .mul_out_valid(ov[1]), .mul_c(mc[1]));

  mod_exp_ctrl #(.EXP_W(4)) u4 (
    .clock(clock), .reset(reset), .start(start_v[2]), .abort(abort),
    .base(base_b), .exp(exp_b[3:0]), .busy(bz[2]), .done(dn[2]), .result(rs[2]),
    .mul_in_valid(mv[2]), .mul_a(ma[2]), .mul_b(mb[2]),
    .mul_out_valid(ov[2]), .mul_c(mc[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // One job: start in cycle 0, optional abort / extra start / reset at given cycles
  task automatic run_job(input string tag, input int w, input logic [127:0] b,
                         input logic [127:0] e, input logic [127:0] want, input int L,
                         input int abort_at, input int restart_at, input int reset_at);
    int ki, pop, exp_done, budget;
    int done_cnt, done_at, busy_first, busy_cnt, pulses, nonunit, stray;
    logic [127:0] em;
    ki = (w == 8) ? 0 : (w == 128) ? 1 : 2;
    em = (w == 128) ? e : (e & ((128'd1 << w) - 128'd1));
    pop = $countones(em);
    exp_done = (w + pop) * (1 + L) + 1;
    budget = exp_done + 5;
    lat[ki] = L;
    done_cnt = 0; done_at = -1; busy_first = -1; busy_cnt = 0;
    pulses = 0; nonunit = 0; stray = 0;

    @(negedge clock);
    base_b = b; exp_b = em; abort = 1'b0; start_v[ki] = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      start_v[ki] = (k == restart_at);
      abort = (k == abort_at);
      if (bz[ki]) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
      end
      if (dn[ki]) begin
        done_cnt++;
        done_at = k;
      end
      if (mv[ki]) begin
        pulses++;
        if (ma[ki] != 128'd1 || mb[ki] != 128'd1) nonunit++;
      end else if (ma[ki] != 128'd0 || mb[ki] != 128'd0) begin
        stray++;
      end
      if (abort_at > 0 && k == abort_at + 1) chk({tag, " busy_after_abort"}, 128'(bz[ki]), 128'd0);
      if (reset_at > 0 && k == reset_at) begin
        chk({tag, " busy_before_reset"}, 128'(bz[ki]), 128'd1);
        #1 reset = 1'b1;
        #1;
        chk({tag, " rst_busy"}, 128'(bz[ki]), 128'd0);
        chk({tag, " rst_done"}, 128'(dn[ki]), 128'd0);
        chk({tag, " rst_result"}, rs[ki], 128'd0);
        chk({tag, " rst_mul_in_valid"}, 128'(mv[ki]), 128'd0);
        chk({tag, " rst_mul_a"}, ma[ki], 128'd0);
        chk({tag, " rst_mul_b"}, mb[ki], 128'd0);
        #2 reset = 1'b0;
        break;
      end
    end
    start_v[ki] = 1'b0;
    abort = 1'b0;

    if (reset_at <= 0) begin
      if (abort_at > 0) begin
        chk({tag, " done_count"}, 128'(done_cnt), 128'd0);
        chk({tag, " result_kept"}, rs[ki], want);
      end else begin
        chk({tag, " result"}, rs[ki], want);
        chk({tag, " done_cycle"}, 128'(done_at), 128'(exp_done));
        chk({tag, " done_count"}, 128'(done_cnt), 128'd1);
        chk({tag, " busy_first"}, 128'(busy_first), 128'd1);
        chk({tag, " busy_cycles"}, 128'(busy_cnt), 128'(exp_done));
        chk({tag, " mul_pulses"}, 128'(pulses), 128'(w + pop));
        chk({tag, " mul_ab_idle_zero"}, 128'(stray), 128'd0);
        if (em == 128'd0) chk({tag, " unit_squares"}, 128'(nonunit), 128'd0);
      end
    end
  endtask

  initial begin
    logic [127:0] rb, re;
    int rw, rl;
    reset = 1'b1;
    abort = 1'b0;
    base_b = 128'd0;
    exp_b = 128'd0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      lat[k] = 1;
    end
    repeat (3) @(negedge clock);
    chk("reset busy", 128'(bz[0]), 128'd0);
    chk("reset done", 128'(dn[0]), 128'd0);
    chk("reset result", rs[0], 128'd0);
    chk("reset mul_in_valid", 128'(mv[0]), 128'd0);
    chk("reset mul_a", ma[0], 128'd0);
    chk("reset mul_b", mb[0], 128'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_job("b3e5", 8, 128'd3, 128'd5, 128'd243, 1, -1, -1, -1);
    run_job("b0e0", 8, 128'd0, 128'd0, 128'd1, 1, -1, -1, -1);
    run_job("w128_e128", 128, 128'd2, 128'd128,
            128'd170141183460469231731687303715882303487, 1, -1, -1, -1);
    run_job("w128_e127", 128, 128'd2, 128'd127, 128'd1 << 127, 1, -1, -1, -1);
    run_job("abort", 8, 128'd3, 128'd5, 128'd0, 1, 6, -1, -1);
    run_job("after_abort", 8, 128'd3, 128'd5, 128'd243, 1, -1, -1, -1);
    run_job("midreset", 8, 128'd3, 128'd5, 128'd0, 1, -1, -1, 14);
    run_job("after_reset", 8, 128'd3, 128'd5, 128'd243, 1, -1, -1, -1);
    run_job("lat3", 4, 128'd7, 128'd13, 128'd96889010407, 3, -1, 5, -1);

    for (int i = 0; i < 24; i++) begin
      rw = ($urandom_range(0, 1) == 0) ? 8 : 4;
      rl = $urandom_range(1, 4);
      rb = {$urandom, $urandom, $urandom, $urandom};
      re = 128'($urandom) & ((128'd1 << rw) - 128'd1);
      run_job($sformatf("rnd%0d", i), rw, rb, re, powmod(rb, re, rw), rl, -1, -1, -1);
    end
    for (int i = 0; i < 2; i++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      re = {$urandom, $urandom, $urandom, $urandom};
      run_job($sformatf("rnd128_%0d", i), 128, rb, re, powmod(rb, re, 128), 1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
